// File: rtl/pipe_cpa_adder_pkg.sv
// Shared constants and helpers for the Booth-4/Wallace multiplier family.
// Holds the final-adder row alignment and the pipeline stage-count helper.
package mult_pkg;

  // Row B enters the final adder two bit positions above row A.
  localparam int CPA_B_OFFSET = 2;

  // Result width and segment width used by the 16x16 multiplier.
  localparam int MULT_W     = 32;
  localparam int MULT_SEG_W = 8;

  function automatic int seg_count(input int w, input int seg_w);
    return (w + seg_w - 1) / seg_w;
  endfunction

endpackage

// File: rtl/pipe_cpa_adder_if.sv
// Operand/result handshake bundle for the pipelined final adder.
// The adder connects through the slave modport; its feeder and consumer use master.
interface pipe_cpa_adder_if
  import mult_pkg::*;
#(
  parameter int W = MULT_W
);
  logic         in_valid;
  logic         in_ready;
  logic [W-2:0] A;
  logic [W-4:0] B;
  logic         sign;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] C;

  modport slave (
    input  in_valid, A, B, sign, out_ready,
    output in_ready, out_valid, C
  );

  modport master (
    output in_valid, A, B, sign, out_ready,
    input  in_ready, out_valid, C
  );
endinterface

// File: rtl/pipe_cpa_adder_seg_stage.sv
// One segment of the pipelined carry-propagate adder plus its register slice.
// Adds bits [K*SEG_W +: SEG_W] (clipped to W-2) with the carry from the previous stage.
module cpa_seg_stage
  import mult_pkg::*;
#(
  parameter int W     = MULT_W,
  parameter int SEG_W = MULT_SEG_W,
  parameter int K     = 0
) (
  input  logic         sys_clk,
  input  logic         sys_rst_n,
  input  logic         adv_i,
  input  logic         v_i,
  input  logic [W-2:0] a_i,
  input  logic [W-2:0] b_i,
  input  logic         c_i,
  input  logic         sign_i,
  output logic         v_o,
  output logic [W-2:0] a_o,
  output logic [W-2:0] b_o,
  output logic         c_o,
  output logic         sign_o
);
  localparam int LO     = K * SEG_W;
  localparam int HI_RAW = LO + SEG_W - 1;
  localparam int HI     = (HI_RAW > W - 2) ? W - 2 : HI_RAW;
  localparam int SW     = HI - LO + 1;

  logic [SW:0]  seg_sum;
  logic [W-2:0] a_d;
  logic         v_q, c_q, sign_q;
  logic [W-2:0] a_q, b_q;

  assign seg_sum = {1'b0, a_i[HI:LO]} + {1'b0, b_i[HI:LO]} + {{SW{1'b0}}, c_i};

  // Row A doubles as the result word: finished segments overwrite their A bits.
  always_comb begin
    a_d        = a_i;
    a_d[HI:LO] = seg_sum[SW-1:0];
  end

  // Data loads only with a valid operand so C stays at its reset value until the first result.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      v_q    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= 1'b0;
      sign_q <= 1'b0;
    end else if (adv_i) begin
      v_q <= v_i;
      if (v_i) begin
        a_q    <= a_d;
        b_q    <= b_i;
        c_q    <= seg_sum[SW];
        sign_q <= sign_i;
      end
    end
  end

  assign v_o    = v_q;
  assign a_o    = a_q;
  assign b_o    = b_q;
  assign c_o    = c_q;
  assign sign_o = sign_q;
endmodule

// File: rtl/pipe_cpa_adder.sv
// Pipelined final carry-propagate adder: C = {sign, (A + (B << 2)) mod 2^(W-1)}.
// Optional macro PIPE_CPA_STAT_EN adds a saturating accepted-input counter acc_cnt.
module pipe_cpa_adder
  import mult_pkg::*;
#(
  parameter int W     = MULT_W,
  parameter int SEG_W = MULT_SEG_W
) (
  input  logic            sys_clk,
  input  logic            sys_rst_n,
  pipe_cpa_adder_if.slave bus
`ifdef PIPE_CPA_STAT_EN
  ,
  output logic [15:0]     acc_cnt
`endif
);
  localparam int NSEG = seg_count(W - 1, SEG_W);

  logic         v_ch    [0:NSEG];
  logic [W-2:0] a_ch    [0:NSEG];
  logic [W-2:0] b_ch    [0:NSEG];
  logic         c_ch    [0:NSEG];
  logic         sign_ch [0:NSEG];
  logic         adv     [0:NSEG-1];
  logic         unused_tail;

  assign v_ch[0]    = bus.in_valid;
  assign a_ch[0]    = bus.A;
  assign b_ch[0]    = {bus.B, {CPA_B_OFFSET{1'b0}}};
  assign c_ch[0]    = 1'b0;
  assign sign_ch[0] = bus.sign;

  genvar gi;
  generate
    for (gi = 0; gi < NSEG; gi++) begin : g_seg
      // A stage may move when it is empty or the stage after it is moving.
      if (gi == NSEG - 1) begin : g_last
        assign adv[gi] = !v_ch[gi+1] || bus.out_ready;
      end else begin : g_mid
        assign adv[gi] = !v_ch[gi+1] || adv[gi+1];
      end

      cpa_seg_stage #(
        .W     (W),
        .SEG_W (SEG_W),
        .K     (gi)
      ) u_stage (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .adv_i     (adv[gi]),
        .v_i       (v_ch[gi]),
        .a_i       (a_ch[gi]),
        .b_i       (b_ch[gi]),
        .c_i       (c_ch[gi]),
        .sign_i    (sign_ch[gi]),
        .v_o       (v_ch[gi+1]),
        .a_o       (a_ch[gi+1]),
        .b_o       (b_ch[gi+1]),
        .c_o       (c_ch[gi+1]),
        .sign_o    (sign_ch[gi+1])
      );
    end
  endgenerate

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = v_ch[NSEG];
  assign bus.C         = {sign_ch[NSEG], a_ch[NSEG]};

  // The final carry is dropped and row B is fully consumed by the last stage.
  assign unused_tail = ^{c_ch[NSEG], b_ch[NSEG]};

`ifdef PIPE_CPA_STAT_EN
  logic [15:0] acc_cnt_q, acc_cnt_d;

  always_comb begin
    acc_cnt_d = acc_cnt_q;
    if (bus.in_valid && adv[0] && acc_cnt_q != 16'hFFFF) begin
      acc_cnt_d = acc_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      acc_cnt_q <= 16'd0;
    end else begin
      acc_cnt_q <= acc_cnt_d;
    end
  end

  assign acc_cnt = acc_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_cpa_adder.sv
// Self-checking bench for pipe_cpa_adder (W=32, SEG_W=8): random traffic against a
// queue-based arithmetic model, plus directed latency, carry, stall and reset cases.
module tb_pipe_cpa_adder;
  localparam int W     = 32;
  localparam int SEG_W = 8;
  localparam int NSEG  = 4;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  pipe_cpa_adder_if #(.W(W)) bus ();

`ifdef PIPE_CPA_STAT_EN
  logic [15:0] acc_cnt;
`endif

  pipe_cpa_adder #(
    .W     (W),
    .SEG_W (SEG_W)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (bus)
`ifdef PIPE_CPA_STAT_EN
    ,
    .acc_cnt   (acc_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q [$];
  int unsigned  acc_model = 0;
  logic         hold_prev = 1'b0;
  logic [W-1:0] c_prev    = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer sum of the two rows, wrapped to W-1 bits, sign on top.
  function automatic logic [W-1:0] model(input logic [W-2:0] a, input logic [W-4:0] b,
                                         input logic s);
    longint unsigned t;
    t = longint'(a) + longint'(b) * 4;
    return {s, t[W-2:0]};
  endfunction

  // Compare process: checks handshake, ordering and hold behaviour every cycle.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      exp_q.delete();
      hold_prev = 1'b0;
      acc_model = 0;
    end else begin
      chk("in_ready", 64'(bus.in_ready), 64'(!(exp_q.size() == NSEG && !bus.out_ready)));
`ifdef PIPE_CPA_STAT_EN
      chk("acc_cnt", 64'(acc_cnt), 64'((acc_model > 65535) ? 65535 : acc_model));
`endif
      if (hold_prev) begin
        chk("hold_out_valid", 64'(bus.out_valid), 64'(1));
        chk("hold_C", 64'(bus.C), 64'(c_prev));
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 64'(bus.out_valid), 64'(0));
        end else if (bus.out_ready) begin
          chk("C_vs_model", 64'(bus.C), 64'(exp_q.pop_front()));
        end
      end
      hold_prev = bus.out_valid && !bus.out_ready;
      c_prev    = bus.C;
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.A, bus.B, bus.sign));
        acc_model++;
      end
    end
  end

  task automatic send_one(input logic [W-2:0] a, input logic [W-4:0] b, input logic s,
                          output int lat, output logic [W-1:0] c);
    int n;
    @(posedge sys_clk); #1;
    bus.in_valid = 1'b1; bus.A = a; bus.B = b; bus.sign = s;
    n = 0;
    @(negedge sys_clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge sys_clk);
      n++;
    end
    @(posedge sys_clk); #1;
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < 50) begin
      @(posedge sys_clk); #1;
      n++;
    end
    lat = n;
    c   = bus.C;
  endtask

  int           lat;
  logic [W-1:0] cres;
  int           k;
  int           cyc;

  initial begin
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.sign = 1'b0; bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_C", 64'(bus.C), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    @(posedge sys_clk); @(posedge sys_clk); #2;
    sys_rst_n = 1'b1;

    // Directed sums with hand-computed results.
    send_one(31'h0000_1234, 29'h0000_0010, 1'b0, lat, cres);
    chk("basic_latency", 64'(lat), 64'(NSEG));
    chk("basic_C", 64'(cres), 64'(32'h0000_1274));
    $display("basic: C=%h latency=%0d", cres, lat);
    send_one(31'h7FFF_FFFC, 29'h0000_0001, 1'b1, lat, cres);
    chk("ripple_C", 64'(cres), 64'(32'h8000_0000));
    $display("ripple: C=%h latency=%0d", cres, lat);
    send_one(31'h7FFF_FFFF, 29'h1FFF_FFFF, 1'b0, lat, cres);
    chk("allones_C", 64'(cres), 64'(32'h7FFF_FFFB));
    $display("allones: C=%h latency=%0d", cres, lat);

    // Stall: fill the pipe with out_ready low, hold, then drain on consecutive cycles.
    @(posedge sys_clk); #1;
    bus.out_ready = 1'b0;
    k = 0; cyc = 0;
    while (k < NSEG && cyc < 20) begin
      bus.in_valid = 1'b1; bus.A = 31'($urandom); bus.B = 29'($urandom); bus.sign = 1'($urandom);
      @(negedge sys_clk);
      if (bus.in_ready) k++;
      @(posedge sys_clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    @(negedge sys_clk);
    chk("full_in_ready", 64'(bus.in_ready), 64'(0));
    chk("full_out_valid", 64'(bus.out_valid), 64'(1));
    repeat (10) @(posedge sys_clk);
    #1 bus.out_ready = 1'b1;
    for (int i = 0; i < NSEG; i++) begin
      @(negedge sys_clk);
      chk("drain_out_valid", 64'(bus.out_valid), 64'(1));
      $display("drain %0d: C=%h", i, bus.C);
    end
    @(negedge sys_clk);
    chk("drain_empty", 64'(bus.out_valid), 64'(0));

    // Reset with three items in flight.
    @(posedge sys_clk); #1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.A = 31'($urandom) | 31'h100; bus.B = 29'($urandom); bus.sign = 1'b1;
      @(posedge sys_clk); #1;
    end
    bus.in_valid = 1'b0;
    @(posedge sys_clk); #1;
    chk("pre_rst_out_valid", 64'(bus.out_valid), 64'(1));
    #1 sys_rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_C", 64'(bus.C), 64'(0));
    chk("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    $display("reset mid-flight: out_valid=%b C=%h", bus.out_valid, bus.C);
    @(posedge sys_clk); @(posedge sys_clk); #2;
    sys_rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      chk("post_rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("post_rst_C", 64'(bus.C), 64'(0));
    end

    // Random traffic with random backpressure.
    k = 0; cyc = 0;
    while (k < 100 && cyc < 5000) begin
      @(posedge sys_clk); #1;
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.A         = 31'($urandom);
      bus.B         = 29'($urandom);
      bus.sign      = 1'($urandom);
      bus.out_ready = 1'($urandom);
      @(negedge sys_clk);
      if (bus.in_valid && bus.in_ready) begin
        $display("rand %0d: A=%h B=%h sign=%b", k, bus.A, bus.B, bus.sign);
        k++;
      end
      cyc++;
    end
    chk("rand_accepts", 64'(k), 64'(100));
    @(posedge sys_clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 100) begin
      @(posedge sys_clk);
      cyc++;
    end
    chk("rand_drained", 64'(exp_q.size()), 64'(0));

`ifdef PIPE_CPA_STAT_EN
    @(posedge sys_clk); #1;
    sys_rst_n = 1'b0;
    #1 chk("stat_rst0", 64'(acc_cnt), 64'(0));
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      @(posedge sys_clk); #1;
      bus.in_valid = 1'b1; bus.A = 31'($urandom); bus.B = 29'($urandom); bus.sign = 1'($urandom);
    end
    @(posedge sys_clk); #1;
    bus.in_valid = 1'b0;
    @(negedge sys_clk);
    chk("stat_saturated", 64'(acc_cnt), 64'(16'hFFFF));
    $display("stat: acc_cnt=%h", acc_cnt);
    #1 sys_rst_n = 1'b0;
    #1 chk("stat_after_rst", 64'(acc_cnt), 64'(0));
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b1;
`endif

    repeat (3) @(posedge sys_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_cpa_adder.md
Name: pipe_cpa_adder

Overview:
- Parametrised, pipelined final carry-propagate adder for the Booth-4/Wallace multiplier family.
- Sums the two compressed partial-product rows and forces the product sign bit onto the MSB, as the fixed 32-bit final adder does.
- Adds segmented carry pipelining, a valid/ready handshake with backpressure, and configurable width.
- Sits between the Wallace tree output registers and the multiplier result port.

Parameters:
- W, 32: output width; A is W-1 bits, B is W-3 bits.
- SEG_W, 8: bits added per pipeline stage.
- NSEG, ceil((W-1)/SEG_W): derived stage count and latency (4 at defaults); the last segment may be narrower.

Ports:
- sys_clk  in  1  clock; all flops rise-edge.
- sys_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block can accept an operand set this cycle.
- A  in  W-1  row A, bit-aligned to the result.
- B  in  W-3  row B, weight 2^2 (B[0] aligns with result bit 2).
- sign  in  1  product sign, copied to C[W-1].
- out_valid  out  1  C valid.
- out_ready  in  1  downstream accepts C.
- C  out  W  result.

Behaviour:
- Arithmetic:
  - C[W-2:0] = (A + (B << 2)) mod 2^(W-1); the carry out of bit W-2 is discarded.
  - C[W-1] = sign.
  - C[1:0] always equals A[1:0].
- Transfers:
  - An input is accepted when in_valid && in_ready.
  - An output is taken when out_valid && out_ready.
- Pipeline structure:
  - NSEG register stages, stage k = 0..NSEG-1.
  - Stage k adds segment k of the sum, bits [k*SEG_W +: SEG_W] clipped to W-2.
  - Stage k uses the registered carry from stage k-1; stage 0 uses carry-in 0.
  - Stage k registers the completed low segments, the carry, the unprocessed high A/B bits, sign, and a valid bit v[k].
  - The stage NSEG-1 register drives C and out_valid directly; there is no extra output flop.
- Advance rule:
  - Stage NSEG-1 advances when !v[NSEG-1] || out_ready.
  - Stage k advances when !v[k] || (stage k+1 advances).
  - in_ready = stage 0 advances. This is combinational from out_ready through the chain; no bubbles, full throughput.
- Latency: accept in cycle t gives out_valid at edge t+NSEG when there is no stall. Throughput is 1 per cycle.
- Stalls:
  - When out_ready=0 and every v[k]=1, in_ready=0.
  - All stage data holds stable; C and out_valid hold until taken.
- A bubble (v[k]=0) is squeezed out while the output is stalled; up to NSEG results are buffered.
- Reset:
  - Reset all v[k]=0, out_valid=0, C=0, and in_ready=1 after reset.
  - Reset mid-operation discards all in-flight data; nothing is emitted after release until new inputs arrive.
- Data flops of invalid stages may load don't-care values, but C must read 0 while out_valid=0 after reset. Clear C's data flops on reset only.
- W=32 with SEG_W ≥ 31 gives NSEG=1, which is legal (single registered adder).

Optional Feature:
- Macro: PIPE_CPA_STAT_EN.
- Defined:
  - Adds output port acc_cnt [15:0].
  - acc_cnt increments on each accepted input and saturates at 16'hFFFF.
  - acc_cnt resets to 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package mult_pkg holds:
  - function seg_count(W, SEG_W), returning the ceiling division.
  - localparam CPA_B_OFFSET = 2.
  - default W and SEG_W constants for the 16x16 multiplier.
- One sub-module, cpa_seg_stage: one segment adder plus its register slice, with valid and advance inputs. It is instantiated NSEG times in a generate loop.
- Bits of a segment are summed with existing compressor_3_2/half_adder cells, or with a behavioural add.

Test Plan:
- Basic sum at W=32, SEG_W=8: A=31'h0000_1234, B=29'h0000_0010, sign=0 -> C=32'h0000_1274, out_valid 4 cycles after accept.
- Full carry ripple across all segments: A=31'h7FFF_FFFC, B=29'h1, sign=1 -> C=32'h8000_0000 (sum wraps, sign forced).
- Back-to-back with random stalls:
  - Stimulus: 100 random vectors, out_ready toggled randomly.
  - Required: outputs in order and equal to the model; no loss or duplication.
  - Required: in_ready=0 only when 4 results are held and out_ready=0.
- Stall hold: out_ready=0 for 10 cycles with the pipe full -> C and out_valid stable; then out_ready=1 drains 4 results on consecutive cycles.
- Reset mid-flight: assert sys_rst_n=0 with 3 items in flight -> out_valid=0 and C=0 immediately (asynchronous); no stale output after release.
- Stat (PIPE_CPA_STAT_EN defined): 70000 accepts -> acc_cnt=16'hFFFF; after reset acc_cnt=0.
